pdm_multi_capture: RTL and testbench

- Parametrised multi-microphone PDM front end.
- Generates one shared PDM clock and samples DATA_LINES data pins on both clock edges: left on rising, right on falling, giving 2*DATA_LINES channels.
- Deserialises each enabled channel into PACK_WIDTH-bit words and drains them through a single valid/ready stream to the downstream CIC/PCM filter bank.
- Unlike the single-line interface, it adds per-channel enables, packing, output buffering and overrun detection.

---
 rtl/pdm_multi_capture.sv | 183 ++++++++++++++++++
 tb/tb_pdm_multi_capture.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_multi_capture.sv
// pdm_multi_capture: shared PDM clock generator and multi-line dual-edge
// capture. Each enabled channel is packed into PACK_WIDTH-bit words that are
// buffered in a per-channel hold register and drained through one
// valid/ready stream with fixed lowest-index-first priority.
module pdm_multi_capture #(
  parameter int DATA_LINES  = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int SYNC_STAGES = 3,
  parameter int PACK_WIDTH  = 8,
  localparam int CH_W       = $clog2(2 * DATA_LINES)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [DIV_WIDTH-1:0]    clock_divisor_i,
  input  logic [2*DATA_LINES-1:0] channel_enable_i,
  input  logic                    clear_overrun_i,
  input  logic [DATA_LINES-1:0]   pdm_data_i,
  output logic                    pdm_clk_o,
  output logic [PACK_WIDTH-1:0]   sample_o,
  output logic [CH_W-1:0]         sample_channel_o,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic [2*DATA_LINES-1:0] overrun_o
);

  localparam int NCH   = 2 * DATA_LINES;
  localparam int CNT_W = $clog2(PACK_WIDTH);

  logic [DIV_WIDTH-1:0]  div_cnt_q;
  logic                  pdm_clk_q;
  logic                  div_wrap;
  logic [SYNC_STAGES:0]  rise_q;
  logic [SYNC_STAGES:0]  fall_q;
  logic [DATA_LINES-1:0] sync_q [SYNC_STAGES];

  logic [PACK_WIDTH-1:0] hold_word [NCH];
  logic [NCH-1:0]        hold_full;
  logic [NCH-1:0]        xfer_ch;
  logic [NCH-1:0]        avail;
  logic [NCH-1:0]        overrun;

  logic                  out_valid_q;
  logic [CH_W-1:0]       out_ch_q;
  logic [PACK_WIDTH-1:0] out_data_q;
  logic                  sel_valid;
  logic [CH_W-1:0]       sel_idx;

  // The counter simply rolls over when a new divisor is below its value.
  assign div_wrap = (div_cnt_q == clock_divisor_i);

  // Divider: toggle pdm_clk every clock_divisor_i+1 cycles; forced low when disabled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
    end else if (!enable_i) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
    end else if (div_wrap) begin
      div_cnt_q <= '0;
      pdm_clk_q <= ~pdm_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Edge strobes registered in the toggle cycle, then delayed to line up with the synchroniser.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else if (!enable_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= {rise_q[SYNC_STAGES-1:0], div_wrap & ~pdm_clk_q};
      fall_q <= {fall_q[SYNC_STAGES-1:0], div_wrap & pdm_clk_q};
    end
  end

  // Multi-stage synchroniser for the asynchronous data pins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pdm_data_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam int LINE = gi / 2;

    logic                  strobe;
    logic                  done;
    logic [PACK_WIDTH-1:0] word_new;
    logic [PACK_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [PACK_WIDTH-1:0] hold_q;
    logic                  full_q;
    logic                  ovr_q;

    // Even channels are the left mic (rising edge), odd channels the right mic.
    assign strobe   = (gi % 2 == 0) ? rise_q[SYNC_STAGES] : fall_q[SYNC_STAGES];
    assign word_new = {shift_q[PACK_WIDTH-2:0], sync_q[SYNC_STAGES-1][LINE]};
    assign done     = enable_i & channel_enable_i[gi] & strobe
                    & (bit_cnt_q == CNT_W'(PACK_WIDTH - 1));
    assign xfer_ch[gi]   = out_valid_q & sample_ready_i & (out_ch_q == CH_W'(gi));
    assign hold_word[gi] = hold_q;
    assign hold_full[gi] = full_q;
    assign overrun[gi]   = ovr_q;

    // Shift in one bit per strobe, MSB first; idle channels are held cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (!enable_i || !channel_enable_i[gi]) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (strobe) begin
        shift_q   <= word_new;
        bit_cnt_q <= done ? '0 : bit_cnt_q + 1'b1;
      end
    end

    // Hold register: accept a finished word when empty or being drained, else flag overrun.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hold_q <= '0;
        full_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (done && (!full_q || xfer_ch[gi])) begin
          hold_q <= word_new;
          full_q <= 1'b1;
        end else if (xfer_ch[gi]) begin
          full_q <= 1'b0;
        end
        if (done && full_q && !xfer_ch[gi]) ovr_q <= 1'b1;
        else if (clear_overrun_i)           ovr_q <= 1'b0;
      end
    end
  end

  // A channel being accepted this cycle is excluded so it is not presented twice.
  assign avail = hold_full & ~xfer_ch;

  // Fixed priority: lowest-index full channel wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (avail[c]) begin
        sel_valid = 1'b1;
        sel_idx   = CH_W'(c);
      end
    end
  end

  // Registered output stage: keep the presented word until it is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else if (!(out_valid_q && !sample_ready_i)) begin
      out_valid_q <= sel_valid;
      if (sel_valid) begin
        out_ch_q   <= sel_idx;
        out_data_q <= hold_word[sel_idx];
      end
    end
  end

  assign pdm_clk_o        = pdm_clk_q;
  assign sample_o         = out_data_q;
  assign sample_channel_o = out_ch_q;
  assign sample_valid_o   = out_valid_q;
  assign overrun_o        = overrun;

endmodule

// File: tb/tb_pdm_multi_capture.sv
// Testbench for pdm_multi_capture: event-queue model of the PDM capture path
// checked every cycle, plus directed scenarios with hand-computed timings.
`timescale 1ns/1ps
module tb_pdm_multi_capture;

  localparam int DL = 2, DW = 8, S = 3, PW = 8, NCH = 4, CHW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           clr = 1'b0;
  logic           ready = 1'b1;
  logic [DW-1:0]  div = 8'd3;
  logic [NCH-1:0] chen = 4'b0001;
  logic [DL-1:0]  pin_set = '0;
  bit             mirror = 1'b0;
  logic [DL-1:0]  pins = '0;

  logic           pclk, valid;
  logic [PW-1:0]  data;
  logic [CHW-1:0] ch;
  logic [NCH-1:0] ovr;

  pdm_multi_capture #(
    .DATA_LINES(DL), .DIV_WIDTH(DW), .SYNC_STAGES(S), .PACK_WIDTH(PW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clock_divisor_i(div),
    .channel_enable_i(chen), .clear_overrun_i(clr), .pdm_data_i(pins),
    .pdm_clk_o(pclk), .sample_o(data), .sample_channel_o(ch),
    .sample_valid_o(valid), .sample_ready_i(ready), .overrun_o(ovr)
  );

  always #5 clk = ~clk;

  // Line 0 can follow pdm_clk (high around rises, low around falls).
  always @(negedge clk) pins = mirror ? {pin_set[1], pclk} : pin_set;

  int n_cmp = 0, n_bad = 0;
  longint tn = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int elapsed();
    return int'(($time - tn) / 10);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { int due; bit rise; } ev_t;
  ev_t evq[$];
  bit [DL-1:0] hist [8];
  int  cyc = 0;
  int  m_cnt = 0;
  bit  m_pclk = 0, m_valid = 0;
  int  m_ch = 0, m_data = 0;
  int  m_sr [NCH], m_nb [NCH], m_hold [NCH];
  bit  [NCH-1:0] m_full = '0, m_ovr = '0;

  // input/output values sampled shortly before each rising edge
  bit s_rst = 1, s_en = 0, s_clr = 0, s_ready = 1, s_valid = 0;
  int s_div = 3, s_data = 0, s_ch = 0;
  bit [NCH-1:0] s_chen = '0;
  bit [DL-1:0]  s_pins = '0;

  int got_ch[$], got_d[$], got_cyc[$];

  task automatic model_step();
    bit xfer, nv, b;
    int xch, nch, nd;
    bit [NCH-1:0] comp, setov;
    int word [NCH];
    ev_t ev;
    cyc++;
    hist[cyc % 8] = s_pins;
    if (s_rst) begin
      evq.delete();
      m_cnt = 0; m_pclk = 0; m_valid = 0; m_ch = 0; m_data = 0;
      m_full = '0; m_ovr = '0;
      for (int c = 0; c < NCH; c++) begin m_sr[c] = 0; m_nb[c] = 0; m_hold[c] = 0; end
      return;
    end
    xfer = m_valid && s_ready;
    xch  = m_ch;
    if (!(m_valid && !s_ready)) begin
      nv = 0; nch = 0; nd = 0;
      for (int c = 0; c < NCH; c++)
        if (!nv && m_full[c] && !(xfer && xch == c)) begin nv = 1; nch = c; nd = m_hold[c]; end
      m_valid = nv;
      if (nv) begin m_ch = nch; m_data = nd; end
    end
    comp = '0; setov = '0;
    for (int c = 0; c < NCH; c++) word[c] = 0;
    if (!s_en) begin
      evq.delete();
      m_cnt = 0; m_pclk = 0;
      for (int c = 0; c < NCH; c++) begin m_sr[c] = 0; m_nb[c] = 0; end
    end else begin
      for (int c = 0; c < NCH; c++) if (!s_chen[c]) begin m_sr[c] = 0; m_nb[c] = 0; end
      while (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        for (int c = 0; c < NCH; c++) begin
          if (s_chen[c] && ((c % 2 == 0) == ev.rise)) begin
            b = hist[(cyc - S) % 8][c / 2];
            m_sr[c] = ((m_sr[c] << 1) | int'(b)) & ((1 << PW) - 1);
            m_nb[c]++;
            if (m_nb[c] == PW) begin comp[c] = 1; word[c] = m_sr[c]; m_nb[c] = 0; end
          end
        end
      end
      if (m_cnt == s_div) begin
        m_cnt = 0;
        evq.push_back('{due: cyc + S + 1, rise: !m_pclk});
        m_pclk = !m_pclk;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << DW);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (comp[c]) begin
        if (!m_full[c] || (xfer && xch == c)) begin m_hold[c] = word[c]; m_full[c] = 1; end
        else setov[c] = 1;
      end else if (xfer && xch == c) begin
        m_full[c] = 0;
      end
    end
    if (s_clr) m_ovr = '0;
    m_ovr |= setov;
  endtask

  // Monitor: log transfers, advance model, compare, then sample for the next edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!s_rst && s_valid && s_ready) begin
        got_ch.push_back(s_ch); got_d.push_back(s_data); got_cyc.push_back(cyc);
        $display("xfer cyc=%0d ch=%0d data=%02h", cyc, s_ch, s_data);
      end
      model_step();
      #2;
      check("pdm_clk", pclk, m_pclk);
      check("valid", valid, m_valid);
      check("overrun", ovr, m_ovr);
      if (m_valid || s_rst) begin
        check("sample", data, m_data);
        check("channel", ch, m_ch);
      end
      #6;
      s_rst = rst; s_en = en; s_clr = clr; s_ready = ready; s_div = int'(div);
      s_chen = chen; s_pins = pins; s_valid = valid; s_data = int'(data); s_ch = int'(ch);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic restart(input logic [NCH-1:0] c, input logic [DL-1:0] p, input bit m, input logic rdy);
    @(negedge clk); en = 0; ready = 1;
    repeat (6) @(negedge clk);
    clr = 1; @(negedge clk); clr = 0;
    chen = c; pin_set = p; mirror = m;
    repeat (4) @(negedge clk);
    got_ch.delete(); got_d.delete(); got_cyc.delete();
    ready = rdy; en = 1; tn = $time;
  endtask

  task automatic watch(input int n, output int v1, output int v2, output int p1, output int p2);
    bit pv, pp;
    v1 = -1; v2 = -1; p1 = -1; p2 = -1; pv = valid; pp = pclk;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (valid && !pv) begin if (v1 < 0) v1 = k; else if (v2 < 0) v2 = k; end
      if (pclk && !pp) begin if (p1 < 0) p1 = k; else if (p2 < 0) p2 = k; end
      pv = valid; pp = pclk;
    end
  endtask

  task automatic wait_valid(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (valid) break;
    end
  endtask

  task automatic wait_until(input int k);
    while (elapsed() < k) @(negedge clk);
  endtask

  int v1, v2, p1, p2, k, nbad_ch;
  int exp_ch [4] = '{0, 2, 1, 3};
  int exp_d  [4] = '{8'hFF, 8'h00, 8'h00, 8'h00};

  initial begin
    // Reset state
    #1;
    check("rst_valid", valid, 0);
    check("rst_pclk", pclk, 0);
    check("rst_sample", data, 0);
    check("rst_overrun", ovr, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    // Single channel, constant 1 on line 0
    restart(4'b0001, 2'b01, 0, 1'b1);
    watch(200, v1, v2, p1, p2);
    check("t1_first_pclk_rise", p1, 4);
    check("t1_pclk_period", p2 - p1, 8);
    check("t1_first_valid", v1, 65);
    check("t1_word_gap", v2 - v1, 64);
    check("t1_n_words", got_d.size(), 3);
    nbad_ch = 0;
    foreach (got_d[i]) if (got_ch[i] != 0 || got_d[i] != 8'hFF) nbad_ch++;
    check("t1_words_ch0_ff", nbad_ch, 0);
    check("t1_overrun", ovr, 0);

    // All channels, line 0 follows pdm_clk, line 1 low
    restart(4'b1111, 2'b00, 1, 1'b1);
    repeat (80) @(negedge clk);
    check("t2_n_words", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      check("t2_order_ch", got_ch[i], exp_ch[i]);
      check("t2_order_data", got_d[i], exp_d[i]);
    end
    if (got_cyc.size() >= 2) check("t2_ch0_ch2_back_to_back", got_cyc[1] - got_cyc[0], 1);
    mirror = 0;

    // Backpressure and overrun
    restart(4'b0001, 2'b01, 0, 1'b0);
    wait_valid(300);
    check("t3_first_valid", elapsed(), 65);
    for (int i = 0; i < 300; i++) begin
      if (ovr[0]) break;
      @(negedge clk);
    end
    check("t3_overrun_cycle", elapsed(), 128);
    check("t3_overrun_flag", ovr, 4'b0001);
    check("t3_held_word", data, 8'hFF);
    ready = 1;
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
    check("t3_overrun_cleared", ovr, 0);
    check("t3_n_delivered", got_d.size(), 1);
    if (got_d.size() > 0) check("t3_delivered_word", got_d[0], 8'hFF);

    // Completion coinciding with acceptance of the previous word
    restart(4'b0001, 2'b01, 0, 1'b0);
    wait_valid(300);
    check("t4_first_valid", elapsed(), 65);
    wait_until(127);
    ready = 1;
    @(negedge clk);
    ready = 0;
    check("t4_valid_gap", valid, 0);
    @(negedge clk);
    check("t4_new_word_valid", valid, 1);
    check("t4_no_overrun", ovr, 0);
    check("t4_n_delivered", got_d.size(), 1);
    ready = 1;

    // Enable dropped mid-word, then restored
    restart(4'b0001, 2'b00, 0, 1'b1);
    k = 0;
    for (int i = 0; i < 100 && k < 5; i++) begin
      @(negedge clk);
      if (pclk && !pins[1] && elapsed() % 8 == 4) k++;
    end
    check("t5_fifth_rise", elapsed(), 36);
    en = 0;
    @(negedge clk);
    check("t5_pclk_forced_low", pclk, 0);
    pin_set = 2'b01;
    repeat (10) @(negedge clk);
    check("t5_no_partial_word", got_d.size(), 0);
    en = 1; tn = $time;
    wait_valid(300);
    check("t5_first_valid", elapsed(), 65);
    @(negedge clk);
    check("t5_n_words", got_d.size(), 1);
    if (got_d.size() > 0) check("t5_word_post_enable", got_d[0], 8'hFF);

    // Asynchronous reset with a word pending
    restart(4'b0001, 2'b01, 0, 1'b0);
    wait_valid(300);
    wait_until(68);
    check("t6_pre_valid", valid, 1);
    check("t6_pre_pclk", pclk, 1);
    #1 rst = 1;
    #1;
    check("t6_async_valid", valid, 0);
    check("t6_async_pclk", pclk, 0);
    check("t6_async_sample", data, 0);
    check("t6_async_channel", ch, 0);
    check("t6_async_overrun", ovr, 0);
    repeat (2) @(negedge clk);
    got_ch.delete(); got_d.delete(); got_cyc.delete();
    ready = 1; rst = 0; tn = $time;
    watch(100, v1, v2, p1, p2);
    check("t6_first_pclk_rise", p1, 4);
    check("t6_first_valid", v1, 65);
    check("t6_n_words", got_d.size(), 1);
    if (got_d.size() > 0) check("t6_word", got_d[0], 8'hFF);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
